// File: rtl/max11100_spi_sampler.sv
// SPI read engine for the MAX11100 16-bit ADC: one trigger runs a 24-SCLK frame,
// discards the conversion-phase bits and returns the result with a one-cycle strobe.
module max11100_spi_sampler #(
    parameter int CLK_DIV_HALF = 13,
    parameter int LEAD_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int QUIET_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trigger,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_ready,
    output logic                 busy,
    output logic                 overrun,
    output logic                 spi_sclk,
    output logic                 spi_cs,
    input  logic                 spi_miso
);

    localparam int N  = LEAD_BITS + DATA_BITS;
    localparam int HW = $clog2(CLK_DIV_HALF + 1);
    localparam int BW = $clog2(N + 1);
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    localparam logic [HW-1:0] HALF_LAST  = HW'(CLK_DIV_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);
    localparam logic [BW-1:0] LEAD_FIRST = BW'(LEAD_BITS);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, QUIET} state_t;

    state_t               state;
    logic [HW-1:0]        half_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [QW-1:0]        quiet_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 capture;

    // MISO is sampled on the cycle that ends a high phase, i.e. on the SCLK falling edge.
    assign capture = (state == SHIFT) && spi_sclk && (half_cnt == HALF_LAST) &&
                     (bit_cnt >= LEAD_FIRST);

    always_ff @(posedge clk) begin
        if (capture) begin
            shift_reg <= {shift_reg[DATA_BITS-2:0], spi_miso};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            spi_cs     <= 1'b1;
            spi_sclk   <= 1'b0;
            busy       <= 1'b0;
            data       <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            quiet_cnt  <= '0;
        end else begin
            data_ready <= 1'b0;
            overrun    <= trigger && busy;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state    <= SHIFT;
                        spi_cs   <= 1'b0;
                        busy     <= 1'b1;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        spi_sclk <= ~spi_sclk;
                        if (spi_sclk) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                state <= HOLD;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // SCLK stays low for one more half period before CS is released.
                    if (half_cnt == HALF_LAST) begin
                        spi_cs     <= 1'b1;
                        data       <= shift_reg;
                        data_ready <= 1'b1;
                        quiet_cnt  <= '0;
                        state      <= QUIET;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                QUIET: begin
                    if (quiet_cnt == QUIET_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
